// File: rtl/rv32im_muldiv_unit.sv
// RV32 M-extension multiply/divide: radix-2 iterative, one bit per cycle, 33-cycle latency
// (1 cycle for divide-by-zero / signed overflow); o_busy stalls the pipeline, starts are never queued.
module rv32im_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = 6;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept, fast, div_zero, div_ovf, last;
    logic               a_signed, b_signed, sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_res;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   div_diff, div_sel, div_fix, calc_res;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_step, div_step, step, prod_fix;

    assign accept   = (state_q == S_IDLE) && i_start && !i_flush;
    assign a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign sa       = a_signed && i_rs1_data[WIDTH-1];
    assign sb       = b_signed && i_rs2_data[WIDTH-1];
    assign a_mag    = sa ? -i_rs1_data : i_rs1_data;
    assign b_mag    = sb ? -i_rs2_data : i_rs2_data;

    assign div_zero = i_op[2] && (i_rs2_data == '0);
    assign div_ovf  = i_op[2] && !i_op[0] && (i_rs1_data == INT_MIN) && (i_rs2_data == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (i_op[1] ? i_rs1_data : '1) : (i_op[1] ? '0 : INT_MIN);

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend/quotient}, shifted left each step.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = rem_sh >= {1'b0, opb_q};
    assign div_diff = rem_sh[WIDTH-1:0] - opb_q;
    assign div_step = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    assign step     = op_q[2] ? div_step : mul_step;
    assign prod_fix = neg_q ? -step : step;
    assign div_sel  = op_q[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    assign div_fix  = neg_q ? -div_sel : div_sel;
    assign calc_res = op_q[2] ? div_fix
                    : ((op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);
    assign last     = (cnt_q == CW'(WIDTH-1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
                S_CALC:  if (last) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy  = (state_q != S_IDLE);
        o_valid = (state_q == S_DONE);
    end

    always_comb begin
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (accept) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opb_d = b_mag;
            cnt_d = '0;
            op_d  = i_op;
            // Remainder takes the dividend's sign; product and quotient take the xor.
            neg_d = (i_op == OP_REM) ? sa : (sa ^ sb);
            if (fast) result_d = fast_res;
        end else if ((state_q == S_CALC) && !i_flush) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (last) result_d = calc_res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign o_result = result_q;
endmodule

// File: doc/rv32im_muldiv_unit.md
RV32IM_MULDIV_UNIT -- requirements
Module: rv32im_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_start  input  1  request to begin an operation; accepted only in IDLE.
REQ-005 The block SHALL have port i_op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port i_rs1_data  input  WIDTH  operand A (multiplicand / dividend).
REQ-007 The block SHALL have port i_rs2_data  input  WIDTH  operand B (multiplier / divisor).
REQ-008 The block SHALL have port i_flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 The block SHALL have port o_busy  output  1  high whenever state is not IDLE; drives the pipeline stall.
REQ-010 The block SHALL have port o_valid  output  1  single-cycle pulse marking o_result as new.
REQ-011 The block SHALL have port o_result  output  WIDTH  registered result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; IDLE->CALC on an accepted normal start, IDLE->DONE on an accepted fast-path start, CALC->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-013 An accepted start (i_start=1, state IDLE, i_flush=0) SHALL latch i_op and both operands; i_op and operands are ignored at all other times.
REQ-014 i_start in CALC or DONE SHALL be ignored, with no queuing.
REQ-015 On acceptance, operands SHALL be converted to magnitudes when signed: both for MULH, DIV and REM; rs1 only for MULHSU; neither for MUL, MULHU, DIVU and REMU.
REQ-016 Signs SHALL be recorded at acceptance: product sign = sA xor sB, quotient sign = sA xor sB, remainder sign = sA.
REQ-017 CALC SHALL perform exactly one iteration per cycle under a 6-bit counter (0..31): a radix-2 shift-add for a 64-bit unsigned product, or a restoring shift-subtract for a 32-bit quotient and remainder.
REQ-018 On entering DONE, o_result SHALL be loaded with the sign-corrected selection: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-019 Sign correction SHALL be the two's complement of the full 64-bit product, or of the quotient or remainder, when the recorded sign is 1.
REQ-020 Normal latency: with start accepted at edge E, o_valid SHALL be high during the cycle after edge E+33 (32 CALC cycles plus one load into DONE); o_busy SHALL be high from E+1 until the edge that returns to IDLE.
REQ-021 Divide by zero SHALL take the fast path: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = rs1 unmodified.
REQ-022 Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF) SHALL take the fast path: quotient = 0x80000000, remainder = 0.
REQ-023 On the fast path, the block SHALL go directly to DONE at edge E+1, with o_valid high for the cycle following E+1.
REQ-024 o_valid SHALL be high only in DONE, for exactly one cycle.
REQ-025 o_result SHALL hold its value after DONE until the next DONE entry.
REQ-026 i_flush=1 SHALL force IDLE at the next edge from any state, produce no o_valid, and leave o_result unchanged.
REQ-027 When i_flush and i_start are both high in IDLE, flush SHALL win and the start SHALL not be accepted.
REQ-028 Flush during DONE SHALL not retract the o_valid pulse already visible in that cycle.
REQ-029 Datapath registers SHALL total at most 64-bit accumulator + 32-bit operand + 6-bit counter + sign/op flags; no combinational 32x32 multiplier is permitted.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately force state IDLE, o_busy=0, o_valid=0, o_result=0, counter=0 and all internal accumulators to 0, including mid-operation.
REQ-031 After reset deassertion, the first rising edge with i_start=1 SHALL be accepted normally.

Verification
REQ-032 MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid exactly 33 cycles after the start edge, o_busy high for 33 cycles.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0, each at latency 1.
REQ-036 Start MUL, then i_flush at CALC cycle 10 -> IDLE next edge, no o_valid, o_result keeps its prior value; i_start pulses during CALC are ignored.
REQ-037 Drive i_rst_n low mid-CALC -> o_busy, o_valid and o_result are 0 immediately; a new DIVU 9/3 after release -> 3 at normal latency.
